// File: rtl/relm_fp_pack.sv
// relm_fp_pack: normalise / round-to-nearest-even / pack back end for the
// ReLM custom FP ops. Takes the unpacked header (sign, biased exponent,
// inf and zero flags) plus a 32-bit mantissa with carry and sticky bits,
// and returns an IEEE-754 single. Denormal results flush to signed zero.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE. out_valid, once raised,
// stays high with out_data/out_inexact held stable until out_ready is seen.
module relm_fp_pack #(
    parameter int WD = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WD-1:0] in_hdr,
    input  logic [WD-1:0] in_m,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WD-1:0] out_data,
    output logic          out_inexact,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_sign;
    logic [31:0]        r_m;
    logic signed [9:0]  r_e;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WD-1:0]      r_out_data;
    logic               r_out_inexact;

    // Rounding datapath, only meaningful while in ROUND.
    logic [22:0]        w_frac;
    logic               w_guard;
    logic               w_sticky;
    logic               w_round_up;
    logic [23:0]        w_frac_sum;
    logic signed [9:0]  w_e_rnd;

    // Round to nearest even on the 23-bit fraction below the hidden bit.
    always_comb begin
        w_frac     = r_m[29:7];
        w_guard    = r_m[6];
        w_sticky   = |r_m[5:0];
        w_round_up = w_guard & (w_sticky | r_m[7]);
        w_frac_sum = {1'b0, w_frac} + {23'd0, w_round_up};
        // A carry out of the fraction leaves frac bits at zero and bumps e.
        w_e_rnd    = r_e + (w_frac_sum[23] ? 10'sd1 : 10'sd0);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_sign        <= 1'b0;
            r_m           <= 32'd0;
            r_e           <= 10'sd0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_inexact <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_sign     <= in_hdr[31];
                        r_m        <= in_m;
                        r_e        <= signed'({2'b00, in_hdr[30:23]});
                        // Special results skip the datapath; out_valid is
                        // raised one edge later from DONE.
                        if (in_hdr[22]) begin
                            r_out_data    <= {in_hdr[31], 8'hFF, 23'd0};
                            r_out_inexact <= 1'b0;
                            r_state       <= DONE;
                        end else if (in_hdr[21] || (in_m == 32'd0)) begin
                            r_out_data    <= {in_hdr[31], 31'd0};
                            r_out_inexact <= 1'b0;
                            r_state       <= DONE;
                        end else begin
                            r_state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (r_m[31]) begin
                        // Carry: shift right, folding the lost bit into sticky.
                        r_m <= {1'b0, r_m[31:2], r_m[1] | r_m[0]};
                        r_e <= r_e + 10'sd1;
                    end else if (r_m[30]) begin
                        r_state <= ROUND;
                    end else if (r_e <= 10'sd1) begin
                        // Would go denormal: flush to signed zero.
                        r_out_data    <= {r_sign, 31'd0};
                        r_out_inexact <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_m <= r_m << 1;
                        r_e <= r_e - 10'sd1;
                    end
                end
                ROUND: begin
                    if (w_e_rnd >= 10'sd255) begin
                        r_out_data    <= {r_sign, 8'hFF, 23'd0};
                        r_out_inexact <= 1'b1;
                    end else if (w_e_rnd <= 10'sd0) begin
                        r_out_data    <= {r_sign, 31'd0};
                        r_out_inexact <= 1'b1;
                    end else begin
                        r_out_data    <= {r_sign, w_e_rnd[7:0], w_frac_sum[22:0]};
                        r_out_inexact <= w_guard | w_sticky;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_inexact = r_out_inexact;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_relm_fp_pack.sv
// Directed bench for relm_fp_pack: hand-computed vectors for normalise,
// rounding, range limits, special inputs, output back-pressure and reset.
module tb_relm_fp_pack;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_hdr;
  logic [31:0] in_m;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_errors;

  relm_fp_pack #(.WD(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_hdr      (in_hdr),
    .in_m        (in_m),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact),
    .dbg_state   (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_hdr(input logic s, input logic [7:0] e,
                                         input logic inf, input logic zero);
    return {s, e, inf, zero, 21'd0};
  endfunction

  // Drive one request, measure latency, check result, optionally hold
  // out_ready low for `hold` cycles, then complete the handshake.
  // exp_lat < 0 skips the latency comparison.
  task automatic run_req(input string tag, input logic [31:0] hdr, input logic [31:0] m,
                         input logic [31:0] exp_data, input logic exp_inx,
                         input int exp_lat, input int hold);
    int wait_cnt;
    int lat;
    @(negedge clk);
    in_hdr   = hdr;
    in_m     = m;
    in_valid = 1'b1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!in_ready) check({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_hdr   = $urandom;
    in_m     = $urandom;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      check({tag, "_out_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    if (exp_lat >= 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_inexact"}, 32'(out_inexact), 32'(exp_inx));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_data"}, out_data, exp_data);
      check({tag, "_hold_inready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_hdr    = 32'd0;
    in_m      = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_inexact", 32'(out_inexact), 32'd0);

    // normalise paths
    run_req("carry",    mk_hdr(0, 8'd127, 0, 0), 32'h8000_0000, 32'h4000_0000, 1'b0, 3, 0);
    run_req("norm_ok",  mk_hdr(0, 8'd127, 0, 0), 32'h4000_0000, 32'h3F80_0000, 1'b0, 2, 0);
    run_req("lshift",   mk_hdr(0, 8'd127, 0, 0), 32'h1000_0000, 32'h3E80_0000, 1'b0, 4, 0);
    run_req("carry_st", mk_hdr(0, 8'd127, 0, 0), 32'h8000_0001, 32'h4000_0000, 1'b1, 3, 0);

    // rounding
    run_req("tie_even", mk_hdr(0, 8'd127, 0, 0), 32'h4000_0040, 32'h3F80_0000, 1'b1, 2, 0);
    run_req("tie_odd",  mk_hdr(0, 8'd127, 0, 0), 32'h4000_00C0, 32'h3F80_0002, 1'b1, 2, 0);
    run_req("g_st",     mk_hdr(0, 8'd127, 0, 0), 32'h4000_0041, 32'h3F80_0001, 1'b1, 2, 0);
    run_req("st_only",  mk_hdr(0, 8'd127, 0, 0), 32'h4000_0001, 32'h3F80_0000, 1'b1, 2, 0);
    run_req("rnd_carry",mk_hdr(0, 8'd127, 0, 0), 32'h7FFF_FFC0, 32'h4000_0000, 1'b1, 2, 0);

    // range limits
    run_req("ovf",      mk_hdr(0, 8'd254, 0, 0), 32'h8000_0000, 32'h7F80_0000, 1'b1, 3, 0);
    run_req("flush_e1", mk_hdr(1, 8'd1,   0, 0), 32'h2000_0000, 32'h8000_0000, 1'b1, -1, 0);
    run_req("flush_sh", mk_hdr(0, 8'd2,   0, 0), 32'h1000_0000, 32'h0000_0000, 1'b1, -1, 0);
    run_req("e_zero",   mk_hdr(0, 8'd0,   0, 0), 32'h4000_0000, 32'h0000_0000, 1'b1, 2, 0);

    // special inputs
    run_req("inf_zero", mk_hdr(0, 8'd5,   1, 1), 32'h1234_5678, 32'h7F80_0000, 1'b0, 1, 0);
    run_req("zero_flg", mk_hdr(1, 8'd100, 0, 1), 32'h4000_0000, 32'h8000_0000, 1'b0, 1, 0);
    run_req("m_zero",   mk_hdr(0, 8'd100, 0, 0), 32'h0000_0000, 32'h0000_0000, 1'b0, 1, 0);

    // back-pressure: out_ready low for 5 cycles
    run_req("bp",       mk_hdr(0, 8'd127, 0, 0), 32'h4000_0000, 32'h3F80_0000, 1'b0, 2, 5);

    // reset while in NORM (bit 24 needs six left shifts)
    @(negedge clk);
    in_hdr   = mk_hdr(0, 8'd127, 0, 0);
    in_m     = 32'h0100_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rst_mid_in_norm", 32'(dbg_state), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("rst_mid_no_output", 32'(out_valid), 32'd0);
    end
    run_req("after_rst", mk_hdr(0, 8'd127, 0, 0), 32'h8000_0000, 32'h4000_0000, 1'b0, 3, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/relm_fp_pack.md
Name: relm_fp_pack

Overview:
- Multi-cycle normalise/round/pack back end for the ReLM custom FP ops.
- Consumes the unpacked intermediate the custom FP unit leaves in B (header) and A (mantissa) after FADD/FMUL.
- Normalises the mantissa, rounds to nearest even, and emits an IEEE-754 single with a valid/ready handshake.
- Denormals are flushed to zero, consistent with the rest of the FP path.

Parameters:
WD, 32, data width; only 32 is supported.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request (high only in IDLE)
in_hdr  input  WD  [31] sign, [30:23] biased exponent e, [22] inf flag, [21] zero flag, [20:0] ignored
in_m  input  WD  mantissa; bit30 weighs 1.0 at exponent e, bit31 is a carry (2.0), bit0 is sticky
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_data  output  WD  packed single {sign, exp[7:0], frac[22:0]}
out_inexact  output  1  set when any discarded bit (guard or sticky) was nonzero

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high on reset.
  - Reset forces state IDLE, out_valid=0, out_data=0, out_inexact=0, and in_ready=1 in the following cycle.
  - Reset mid-operation abandons the request with no output.
- States: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1. Accept on in_valid & in_ready at the clock edge.
  - Latch sign, m (32b) and e, zero-extended into a 10-bit signed internal exponent.
  - If inf=1: result {s,8'hFF,23'd0}, inexact=0, go to DONE. The inf flag takes priority over the zero flag.
  - Else if zero=1 or in_m==0: result {s,31'd0}, inexact=0, go to DONE.
  - Otherwise go to NORM.
- NORM (one action per cycle):
  - If m[31]=1: m <= {1'b0, m[31:2], m[1]|m[0]}, e <= e+1, stay in NORM.
  - Else if m[30]=1: go to ROUND.
  - Else if e<=1: flush to {s,31'd0}, inexact=1, go to DONE.
  - Else: m <= m<<1, e <= e-1, stay in NORM.
- ROUND (RNE):
  - frac=m[29:7], guard g=m[6], sticky st=|m[5:0].
  - Round up when g & (st | m[7]).
  - A round-up carry out of frac gives frac=0, e=e+1.
  - After rounding, e>=255 gives {s,FF,0} with inexact=1; e<=0 gives {s,0,0}.
  - Otherwise {s,e[7:0],frac}. inexact = g|st (and 1 on overflow or flush).
  - Go to DONE.
- DONE:
  - out_valid=1. out_data and out_inexact are registered and held stable until out_ready.
  - On out_valid & out_ready: out_valid=0 and the next state is IDLE.
  - in_ready stays low during DONE. A new request is taken at the earliest in the cycle after the handshake.
- Latency:
  - Acceptance edge E0. Normal path: out_valid visible after E0 + 2 + k edges, where k is the number of NORM shift cycles (right or left).
  - Special path: out_valid visible after E0+1.
  - Worst case k=30.
- Throughput: one request in flight; no buffering.
- Widths: exponent arithmetic uses 10-bit signed values, so no wrap at 0 or 255. The output is combinationally independent of the inputs after acceptance; the inputs may change freely.

Test Plan:
- Carry normalise: hdr={0,127,0,0}, m=0x80000000 (1.0+1.0) -> out_data=0x40000000, inexact=0, out_valid 3 edges after accept.
- Already normalised: e=127, m=0x40000000 -> 0x3F800000, out_valid 2 edges after accept.
- Left shift: e=127, m=0x10000000 (1.0-0.75) -> 0x3E800000 after 4 edges.
- Rounding:
  - m=0x40000040 (tie, even lsb) -> 0x3F800000, inexact=1.
  - m=0x400000C0 -> 0x3F800002.
  - m=0x7FFFFFC0, e=127 -> 0x40000000 via round carry.
- Range limits:
  - e=254, m=0x80000000 -> 0x7F800000, inexact=1.
  - sign=1, e=1, m=0x20000000 -> 0x80000000.
  - inf=1 with zero=1 -> 0x7F800000 after 1 edge.
- Handshake and reset:
  - out_ready held low 5 cycles -> out_data stable and in_ready=0 throughout.
  - reset asserted in NORM -> no out_valid, in_ready=1 next cycle, a following request completes normally.
